branch_predictor: RTL and testbench

Fetch-side branch predictor; the initiating end of the branch path. At fetch it predicts pc_src and the target for the current PC. At execute, the branch resolution unit reports the actual outcome back through the update port. Direct-mapped table of 2^INDEX_BITS entries; each entry holds a valid bit, tag, target and 2-bit saturating counter. Sits beside the PC register and feeds the next-PC mux ahead of resolution.

---
 rtl/branch_predictor_pkg.sv | 19 +
 rtl/branch_predictor_if.sv | 45 ++++
 rtl/branch_predictor_sat_counter2.sv | 21 ++
 rtl/branch_predictor.sv | 139 +++++++++++++
 tb/tb_branch_predictor.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Counter encodings, FSM states and PC slice positions.
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // Word-aligned PCs: the low two bits never select an entry.
    localparam int PC_IDX_LSB = 2;

    typedef enum logic {
        INIT,
        READY
    } bp_state_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch, prediction and resolution-update bundle of the predictor.
// master = fetch/execute side, slave = predictor.
interface bp_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic            pred_valid;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            pred_hit;
    logic            update_valid;
    logic [XLEN-1:0] update_pc;
    logic            update_taken;
    logic [XLEN-1:0] update_target;
    logic            init_done;

    modport master (
        output fetch_valid,
        output fetch_pc,
        input  pred_valid,
        input  pred_taken,
        input  pred_target,
        input  pred_hit,
        output update_valid,
        output update_pc,
        output update_taken,
        output update_target,
        input  init_done
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        output pred_valid,
        output pred_taken,
        output pred_target,
        output pred_hit,
        input  update_valid,
        input  update_pc,
        input  update_taken,
        input  update_target,
        output init_done
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-value logic.
// Taken counts up to strong-T, not-taken down to strong-NT.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Saturate at either end, otherwise step by one.
    always_comb begin
        ctr_next = ctr;
        unique case (1'b1)
            taken && (ctr != CTR_ST): ctr_next = ctr + 2'd1;
            !taken && (ctr != CTR_SNT): ctr_next = ctr - 2'd1;
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: valid/tag/target/2-bit counter per entry.
// Registered lookup at fetch, trained by resolution updates.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input logic clk,
    input logic rst,
    bp_if.slave bp
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int IDX_MSB = INDEX_BITS + PC_IDX_LSB - 1;
    localparam int TAG_LSB = INDEX_BITS + PC_IDX_LSB;
    localparam int TAG_MSB = TAG_LSB + TAG_BITS - 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic                  valid_q [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
    logic [XLEN-1:0]       tgt_q   [ENTRIES];
    logic [1:0]            ctr_q   [ENTRIES];

    bp_state_e             state_q;
    bp_state_e             state_d;
    logic [INDEX_BITS-1:0] init_idx_q;
    logic                  init_done_q;
    logic                  ready;

    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;
    logic                  f_taken;
    logic [XLEN-1:0]       f_target;

    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic                  u_hit;
    logic [1:0]            u_ctr_next;

    logic                  pred_valid_q;
    logic                  pred_taken_q;
    logic [XLEN-1:0]       pred_target_q;
    logic                  pred_hit_q;

    logic                  unused_pc_bits;

    assign f_idx = bp.fetch_pc[IDX_MSB:PC_IDX_LSB];
    assign f_tag = bp.fetch_pc[TAG_MSB:TAG_LSB];
    assign u_idx = bp.update_pc[IDX_MSB:PC_IDX_LSB];
    assign u_tag = bp.update_pc[TAG_MSB:TAG_LSB];
    assign ready = (state_q == READY);

    assign unused_pc_bits = ^{bp.fetch_pc[PC_IDX_LSB-1:0],
                              bp.update_pc[PC_IDX_LSB-1:0],
                              bp.fetch_pc[XLEN-1:TAG_MSB+1],
                              bp.update_pc[XLEN-1:TAG_MSB+1]};

    // Lookup against pre-update contents; the table is empty until READY.
    assign f_hit = ready && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_taken = f_hit && ctr_q[f_idx][1];
    assign f_target = f_taken ? tgt_q[f_idx] : bp.fetch_pc + PC_STEP;

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    sat_counter2 u_ctr (
        .ctr      (ctr_q[u_idx]),
        .taken    (bp.update_taken),
        .ctr_next (u_ctr_next)
    );

    // Next-state: sweep the table once, then stay ready until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: if (init_idx_q == '1) state_d = READY;
            READY: state_d = READY;
            default: state_d = INIT;
        endcase
    end

    // FSM state, clear pointer and init_done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            init_idx_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) init_idx_q <= init_idx_q + 1'b1;
            init_done_q <= (state_d == READY);
        end
    end

    // Table storage: clear sweep during INIT, training once READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) begin
                valid_q[init_idx_q] <= 1'b0;
            end else if (bp.update_valid) begin
                if (u_hit) begin
                    ctr_q[u_idx] <= u_ctr_next;
                    if (bp.update_taken) tgt_q[u_idx] <= bp.update_target;
                end else if (bp.update_taken) begin
                    valid_q[u_idx] <= 1'b1;
                    tag_q[u_idx] <= u_tag;
                    tgt_q[u_idx] <= bp.update_target;
                    ctr_q[u_idx] <= CTR_ALLOC;
                end
            end
        end
    end

    // Registered prediction; outputs hold while no lookup is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_target_q <= '0;
            pred_hit_q <= 1'b0;
        end else begin
            pred_valid_q <= bp.fetch_valid;
            if (bp.fetch_valid) begin
                pred_taken_q <= f_taken;
                pred_target_q <= f_target;
                pred_hit_q <= f_hit;
            end
        end
    end

    assign bp.pred_valid = pred_valid_q;
    assign bp.pred_taken = pred_taken_q;
    assign bp.pred_target = pred_target_q;
    assign bp.pred_hit = pred_hit_q;
    assign bp.init_done = init_done_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: entry-level reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   started = 1'b0;

    bp_if #(.XLEN(32)) bi ();

    branch_predictor #(
        .XLEN       (32),
        .INDEX_BITS (6),
        .TAG_BITS   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bi.slave)
    );

    always #5 clk = ~clk;

    // Reference model: one record per table slot.
    bit          m_v   [64];
    int          m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ctr [64];
    int          m_cnt;

    logic        e_pv;
    logic        e_taken;
    logic        e_hit;
    logic [31:0] e_tgt;
    logic        e_done;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model advances on each edge from the inputs the DUT sees.
    always @(posedge clk) begin
        int i;
        int t;
        bit h;
        if (rst) begin
            e_pv = 0;
            e_taken = 0;
            e_hit = 0;
            e_tgt = 0;
            e_done = 0;
            m_cnt = 0;
            for (int k = 0; k < 64; k++) m_v[k] = 0;
            started = 1;
        end else begin
            if (bi.fetch_valid) begin
                i = int'((bi.fetch_pc >> 2) & 32'd63);
                t = int'((bi.fetch_pc >> 8) & 32'd255);
                h = (m_cnt >= 64) && m_v[i] && (m_tag[i] == t);
                e_pv = 1;
                e_hit = h;
                e_taken = h && (m_ctr[i] >= 2);
                e_tgt = e_taken ? m_tgt[i] : bi.fetch_pc + 32'd4;
            end else begin
                e_pv = 0;
            end
            if (m_cnt >= 64 && bi.update_valid) begin
                i = int'((bi.update_pc >> 2) & 32'd63);
                t = int'((bi.update_pc >> 8) & 32'd255);
                if (m_v[i] && m_tag[i] == t) begin
                    if (bi.update_taken) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = bi.update_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (bi.update_taken) begin
                    m_v[i] = 1;
                    m_tag[i] = t;
                    m_tgt[i] = bi.update_target;
                    m_ctr[i] = 2;
                end
            end
            if (m_cnt < 64) m_cnt++;
            e_done = (m_cnt >= 64);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("m_pred_valid", 32'(bi.pred_valid), 32'(e_pv));
            chk("m_pred_hit", 32'(bi.pred_hit), 32'(e_hit));
            chk("m_pred_taken", 32'(bi.pred_taken), 32'(e_taken));
            chk("m_pred_target", bi.pred_target, e_tgt);
            chk("m_init_done", 32'(bi.init_done), 32'(e_done));
        end
    end

    // Inputs change just after a falling edge; returns at the next one,
    // when the registered result of this cycle is visible.
    task automatic step(input logic fv, input logic [31:0] fpc,
                        input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utg);
        bi.fetch_valid = fv;
        bi.fetch_pc = fpc;
        bi.update_valid = uv;
        bi.update_pc = upc;
        bi.update_taken = ut;
        bi.update_target = utg;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] pc);
        step(1, pc, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg);
        step(0, 0, 1, pc, tk, tg);
    endtask

    task automatic expect_pred(input string nm, input logic h,
                               input logic tk, input logic [31:0] tg);
        chk({nm, "_hit"}, 32'(bi.pred_hit), 32'(h));
        chk({nm, "_taken"}, 32'(bi.pred_taken), 32'(tk));
        chk({nm, "_target"}, bi.pred_target, tg);
    endtask

    // Run fetches of pc until init_done; returns the cycle it rose.
    task automatic wait_init(input logic [31:0] pc, output int done_at);
        done_at = 0;
        for (int k = 1; k <= 80 && done_at == 0; k++) begin
            if (k == 5) step(1, pc, 1, 32'h900, 1, 32'h1234);
            else fetch(pc);
            if (k == 1) begin
                chk("init_pred_valid", 32'(bi.pred_valid), 32'd1);
                expect_pred("init_first", 0, 0, pc + 32'd4);
            end
            if (k == 63) expect_pred("init_last", 0, 0, pc + 32'd4);
            if (bi.init_done) done_at = k;
        end
    endtask

    initial begin
        int done_at;
        bi.fetch_valid = 0;
        bi.fetch_pc = 0;
        bi.update_valid = 0;
        bi.update_pc = 0;
        bi.update_taken = 0;
        bi.update_target = 0;
        rst = 1;
        @(negedge clk);
        fetch(32'h100);
        chk("rst_pred_valid", 32'(bi.pred_valid), 32'd0);
        chk("rst_pred_target", bi.pred_target, 32'd0);
        chk("rst_init_done", 32'(bi.init_done), 32'd0);

        rst = 0;
        wait_init(32'h100, done_at);
        chk("init_latency", 32'(done_at), 32'd64);

        fetch(32'h900);
        expect_pred("init_upd_ignored", 0, 0, 32'h904);

        upd(32'h200, 1, 32'h180);
        fetch(32'h200);
        expect_pred("alloc", 1, 1, 32'h180);

        upd(32'h200, 0, 32'h0);
        fetch(32'h200);
        expect_pred("hyst_wnt", 1, 0, 32'h204);

        upd(32'h200, 1, 32'h180);
        upd(32'h200, 1, 32'h180);
        upd(32'h200, 0, 32'h0);
        fetch(32'h200);
        expect_pred("hyst_st", 1, 1, 32'h180);

        step(0, 0, 0, 0, 0, 0);
        chk("idle_pred_valid", 32'(bi.pred_valid), 32'd0);
        chk("idle_hold_target", bi.pred_target, 32'h180);

        upd(32'h300, 1, 32'h400);
        fetch(32'h200);
        expect_pred("alias_old", 0, 0, 32'h204);
        fetch(32'h300);
        expect_pred("alias_new", 1, 1, 32'h400);

        step(1, 32'h500, 1, 32'h500, 1, 32'h600);
        expect_pred("collide_rbw", 0, 0, 32'h504);
        fetch(32'h500);
        expect_pred("collide_next", 1, 1, 32'h600);

        upd(32'h704, 0, 32'h777);
        fetch(32'h704);
        expect_pred("nt_miss", 0, 0, 32'h708);

        upd(32'h844, 1, 32'h2000);
        fetch(32'h844);
        expect_pred("pre_rst", 1, 1, 32'h2000);

        rst = 1;
        fetch(32'h844);
        chk("mid_rst_valid", 32'(bi.pred_valid), 32'd0);
        expect_pred("mid_rst", 0, 0, 32'h0);
        chk("mid_rst_init_done", 32'(bi.init_done), 32'd0);
        rst = 0;
        wait_init(32'h500, done_at);
        chk("reinit_latency", 32'(done_at), 32'd64);

        fetch(32'h844);
        expect_pred("after_rst_a", 0, 0, 32'h848);
        fetch(32'h500);
        expect_pred("after_rst_b", 0, 0, 32'h504);

        fetch(32'hFFFF_FFFC);
        expect_pred("wrap", 0, 0, 32'h0);

        step(0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
